dma_desc_dispatcher: RTL and testbench
======================================

Name: dma_desc_dispatcher

Overview:
Upstream feeder for the L1 DMA controller. It accepts descriptors (src, dst, len, last) from the tile scheduler over a valid/ready handshake. Each accepted descriptor is turned into the 32-bit CSR write sequence the DMA config block expects, with backpressure taken from the DMA's descriptor FIFO full flag. The block also services the DMA done interrupt: it counts completed chains and issues the CLEAR_IRQ write, so the scheduler sees one clean pulse per finished chain.

Parameters:
CSR_BASE, 32'h0000_0000, base address of the DMA CSR window; register offsets are fixed and listed under Behaviour.
CNT_W, 4, width of the outstanding-chain counter.
CLR_HOLDOFF, 2, cycles to ignore dma_done_i after a CLEAR_IRQ write, covering the DMA counter update latency.

Ports:
clk  in  1  clock
rstn  in  1  asynchronous, active-low reset
desc_valid_i  in  1  descriptor valid
desc_ready_o  out  1  descriptor accepted when valid&ready
desc_src_i  in  32  source address
desc_dst_i  in  32  destination address
desc_len_i  in  32  byte count
desc_last_i  in  1  last descriptor of chain
csr_wr_en_o  out  1  CSR write strobe, one cycle per write
csr_waddr_o  out  32  CSR write address
csr_wdata_o  out  32  CSR write data
dma_fifo_full_i  in  1  DMA descriptor FIFO full
dma_done_i  in  1  DMA done IRQ, level-high while the DMA's done counter is nonzero
dma_error_i  in  1  DMA error
soft_clear_i  in  1  clears the error state
chain_done_o  out  1  one-cycle pulse per serviced done
outstanding_o  out  CNT_W  chains issued and not yet completed
busy_o  out  1  FSM not in IDLE
error_o  out  1  sticky error flag

Behaviour:
- Register offsets from CSR_BASE: SRC +0x00, DST +0x04, LEN +0x08, CTRL +0x0C (bit0 = push, bit1 = last), CLEAR_IRQ +0x10 (wdata 32'h1).
- Reset values: all outputs 0, FSM in IDLE, counters 0, holdoff counter 0.
- FSM states: IDLE, WR_SRC, WR_DST, WR_LEN, WR_CTRL, CLR_IRQ, CLR_WAIT, ERR.
- IDLE transitions, checked in this priority order:
  - dma_error_i=1 -> ERR.
  - dma_done_i=1 and holdoff=0 and outstanding_o!=0 -> CLR_IRQ.
  - Otherwise, desc_ready_o = ~dma_fifo_full_i. On handshake, latch the descriptor and go to WR_SRC.
- desc_ready_o is 0 in every state other than IDLE.
- Write sequence: WR_SRC, WR_DST and WR_LEN each assert csr_wr_en_o for exactly one cycle with the latched field, then advance.
- WR_CTRL:
  - While dma_fifo_full_i=1, hold the state with csr_wr_en_o=0.
  - Otherwise write {30'b0, last, 1'b1} and return to IDLE.
  - If last=1, increment outstanding_o in the same cycle as the write.
- Minimum throughput: 4 write cycles plus 1 IDLE cycle per descriptor.
- CLR_IRQ: one write to CLEAR_IRQ; pulse chain_done_o; decrement outstanding_o; load holdoff = CLR_HOLDOFF; go to CLR_WAIT.
- CLR_WAIT: decrement holdoff each cycle; move to IDLE when it reaches 0.
- dma_done_i with outstanding_o=0 is spurious: it is ignored and no write is issued.
- A simultaneous increment and decrement of outstanding_o cannot occur, because the two update states are exclusive.
- outstanding_o saturates at 2^CNT_W-1. At that value desc_ready_o is forced 0 whenever the pending descriptor has last=1.
- dma_error_i sampled in any state:
  - An in-progress write sequence finishes its current write.
  - The FSM then enters ERR, which sets error_o.
- ERR: all writes are blocked. soft_clear_i clears error_o and outstanding_o and returns the FSM to IDLE.
- Reset mid-sequence aborts immediately; no partial-write recovery is performed.

Optional Feature:
- Macro DMA_DISP_STATS_EN.
- When defined:
  - Adds output desc_cnt_o [15:0], counting CTRL writes issued. It wraps at 16'hFFFF->0 and is cleared by reset and by soft_clear_i.
  - Adds output stall_cnt_o [15:0], counting cycles spent in WR_CTRL with dma_fifo_full_i=1. It saturates at 16'hFFFF.
- When undefined: neither port exists and no counter logic is present.

Test Plan:
1. Single descriptor, src=0x1000, dst=0x2000, len=0x40, last=1 -> writes in order: (BASE+0,0x1000), (+4,0x2000), (+8,0x40), (+0xC,0x3); outstanding_o=1.
2. Continuation then last: first descriptor last=0, second last=1 -> CTRL writes 0x1 then 0x3; outstanding_o goes 0->0->1.
3. dma_fifo_full_i=1 held 5 cycles during WR_CTRL -> no write during those 5 cycles; CTRL write on the first cycle full=0; desc_ready_o=0 while in IDLE with full=1.
4. outstanding_o=2 with dma_done_i held high -> CLEAR_IRQ write, chain_done_o pulse, outstanding_o=1, then no second clear for CLR_HOLDOFF cycles.
5. dma_error_i asserted during WR_DST -> WR_DST write completes, then ERR with error_o=1 and desc_ready_o=0; soft_clear_i -> IDLE and outstanding_o=0.
6. dma_done_i=1 with outstanding_o=0 -> no CLEAR_IRQ write and no chain_done_o pulse.

Source files
------------

// File: rtl/dma_desc_dispatcher.sv
// Descriptor-to-CSR write sequencer for the L1 DMA, with done-IRQ servicing and chain accounting.
// Optional statistics counters (desc_cnt_o, stall_cnt_o) are built when DMA_DISP_STATS_EN is defined.
module dma_desc_dispatcher #(
  parameter logic [31:0] CSR_BASE    = 32'h0000_0000,
  parameter int          CNT_W       = 4,
  parameter int          CLR_HOLDOFF = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             desc_valid_i,
  output logic             desc_ready_o,
  input  logic [31:0]      desc_src_i,
  input  logic [31:0]      desc_dst_i,
  input  logic [31:0]      desc_len_i,
  input  logic             desc_last_i,
  output logic             csr_wr_en_o,
  output logic [31:0]      csr_waddr_o,
  output logic [31:0]      csr_wdata_o,
  input  logic             dma_fifo_full_i,
  input  logic             dma_done_i,
  input  logic             dma_error_i,
  input  logic             soft_clear_i,
  output logic             chain_done_o,
  output logic [CNT_W-1:0] outstanding_o,
  output logic             busy_o,
  output logic             error_o
`ifdef DMA_DISP_STATS_EN
  ,
  output logic [15:0]      desc_cnt_o,
  output logic [15:0]      stall_cnt_o
`endif
);

  localparam logic [31:0] OFF_SRC  = 32'h00;
  localparam logic [31:0] OFF_DST  = 32'h04;
  localparam logic [31:0] OFF_LEN  = 32'h08;
  localparam logic [31:0] OFF_CTRL = 32'h0C;
  localparam logic [31:0] OFF_CLR  = 32'h10;
  localparam int          HW       = (CLR_HOLDOFF < 1) ? 1 : $clog2(CLR_HOLDOFF + 1);

  typedef enum logic [2:0] {
    IDLE, WR_SRC, WR_DST, WR_LEN, WR_CTRL, CLR_IRQ, CLR_WAIT, ERR
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      src_q, src_d, dst_q, dst_d, len_q, len_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] out_q, out_d;
  logic [HW-1:0]    holdoff_q, holdoff_d;
  logic             error_q, error_d;
  logic             rst_done_q;
  logic             out_sat;
  logic             ready_ok;

  assign out_sat = (out_q == {CNT_W{1'b1}});

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      last_q     <= 1'b0;
      out_q      <= '0;
      holdoff_q  <= '0;
      error_q    <= 1'b0;
      rst_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      len_q      <= len_d;
      last_q     <= last_d;
      out_q      <= out_d;
      holdoff_q  <= holdoff_d;
      error_q    <= error_d;
      rst_done_q <= 1'b1;
    end
  end

  // Write states always complete their own strobe; a sampled error only redirects the next state.
  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    dst_d        = dst_q;
    len_d        = len_q;
    last_d       = last_q;
    out_d        = out_q;
    holdoff_d    = holdoff_q;
    ready_ok     = 1'b0;
    csr_wr_en_o  = 1'b0;
    csr_waddr_o  = '0;
    csr_wdata_o  = '0;
    chain_done_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (dma_error_i) begin
          state_d = ERR;
        end else if (dma_done_i && (holdoff_q == '0) && (out_q != '0)) begin
          state_d = CLR_IRQ;
        end else begin
          // Gated until the first clock after reset so all outputs read 0 during reset.
          ready_ok = rst_done_q & ~dma_fifo_full_i & ~(out_sat & desc_last_i);
          if (desc_valid_i && ready_ok) begin
            src_d   = desc_src_i;
            dst_d   = desc_dst_i;
            len_d   = desc_len_i;
            last_d  = desc_last_i;
            state_d = WR_SRC;
          end
        end
      end
      WR_SRC: begin
        csr_wr_en_o = 1'b1;
        csr_waddr_o = CSR_BASE + OFF_SRC;
        csr_wdata_o = src_q;
        state_d     = dma_error_i ? ERR : WR_DST;
      end
      WR_DST: begin
        csr_wr_en_o = 1'b1;
        csr_waddr_o = CSR_BASE + OFF_DST;
        csr_wdata_o = dst_q;
        state_d     = dma_error_i ? ERR : WR_LEN;
      end
      WR_LEN: begin
        csr_wr_en_o = 1'b1;
        csr_waddr_o = CSR_BASE + OFF_LEN;
        csr_wdata_o = len_q;
        state_d     = dma_error_i ? ERR : WR_CTRL;
      end
      WR_CTRL: begin
        if (!dma_fifo_full_i) begin
          csr_wr_en_o = 1'b1;
          csr_waddr_o = CSR_BASE + OFF_CTRL;
          csr_wdata_o = {30'b0, last_q, 1'b1};
          if (last_q && !out_sat) out_d = out_q + CNT_W'(1);
          state_d = dma_error_i ? ERR : IDLE;
        end else if (dma_error_i) begin
          state_d = ERR;
        end
      end
      CLR_IRQ: begin
        csr_wr_en_o  = 1'b1;
        csr_waddr_o  = CSR_BASE + OFF_CLR;
        csr_wdata_o  = 32'h1;
        chain_done_o = 1'b1;
        if (out_q != '0) out_d = out_q - CNT_W'(1);
        holdoff_d = HW'(CLR_HOLDOFF);
        state_d   = dma_error_i ? ERR : CLR_WAIT;
      end
      CLR_WAIT: begin
        if (holdoff_q <= HW'(1)) begin
          holdoff_d = '0;
          state_d   = IDLE;
        end else begin
          holdoff_d = holdoff_q - HW'(1);
        end
        if (dma_error_i) begin
          holdoff_d = '0;
          state_d   = ERR;
        end
      end
      ERR: begin
        if (soft_clear_i) begin
          out_d     = '0;
          holdoff_d = '0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // ERR is only left through soft_clear_i, so the flag simply tracks the state.
    error_d = (state_d == ERR);
  end

  assign desc_ready_o  = ready_ok;
  assign outstanding_o = out_q;
  assign busy_o        = (state_q != IDLE);
  assign error_o       = error_q;

`ifdef DMA_DISP_STATS_EN
  logic [15:0] desc_cnt_q, stall_cnt_q;
  logic        ctrl_wr, ctrl_stall;

  assign ctrl_wr    = (state_q == WR_CTRL) && !dma_fifo_full_i;
  assign ctrl_stall = (state_q == WR_CTRL) && dma_fifo_full_i;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      desc_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (soft_clear_i)  desc_cnt_q <= '0;
      else if (ctrl_wr)  desc_cnt_q <= desc_cnt_q + 16'd1;
      if (ctrl_stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign desc_cnt_o  = desc_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_dma_desc_dispatcher.sv
// Self-checking bench for dma_desc_dispatcher: table vectors, hand-written corner sequences and
// randomized descriptors checked against a write-sequence / chain-count reference model.
module tb_dma_desc_dispatcher;
  localparam logic [31:0] BASE    = 32'h4000_0000;
  localparam int          CNT_W   = 4;
  localparam int          HOLD    = 2;
  localparam int          MAX_OUT = (1 << CNT_W) - 1;

  logic             clk, rstn;
  logic             desc_valid_i, desc_ready_o;
  logic [31:0]      desc_src_i, desc_dst_i, desc_len_i;
  logic             desc_last_i;
  logic             csr_wr_en_o;
  logic [31:0]      csr_waddr_o, csr_wdata_o;
  logic             dma_fifo_full_i, dma_done_i, dma_error_i, soft_clear_i;
  logic             chain_done_o;
  logic [CNT_W-1:0] outstanding_o;
  logic             busy_o, error_o;

  logic [63:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_done   = 0;
  int          model_out = 0;
  bit          rand_full = 0;

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    logic [31:0] len;
    logic        last;
    int          exp_out;
  } vec_t;
  vec_t tbl[4];

  dma_desc_dispatcher #(.CSR_BASE(BASE), .CNT_W(CNT_W), .CLR_HOLDOFF(HOLD)) dut (
    .clk(clk), .rstn(rstn),
    .desc_valid_i(desc_valid_i), .desc_ready_o(desc_ready_o),
    .desc_src_i(desc_src_i), .desc_dst_i(desc_dst_i), .desc_len_i(desc_len_i),
    .desc_last_i(desc_last_i),
    .csr_wr_en_o(csr_wr_en_o), .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o),
    .dma_fifo_full_i(dma_fifo_full_i), .dma_done_i(dma_done_i), .dma_error_i(dma_error_i),
    .soft_clear_i(soft_clear_i), .chain_done_o(chain_done_o), .outstanding_o(outstanding_o),
    .busy_o(busy_o), .error_o(error_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] wr(input logic [31:0] off, input logic [31:0] d);
    return {BASE + off, d};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // One cycle: scoreboard sample at negedge, then return 1 time unit after the next posedge.
  task automatic tick();
    logic [63:0] e;
    @(negedge clk);
    if (csr_wr_en_o) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr=%h data=%h, required no write", csr_waddr_o, csr_wdata_o);
      end else begin
        e = exp_q.pop_front();
        check("csr_write", {csr_waddr_o, csr_wdata_o}, e);
      end
    end
    if (chain_done_o) n_done++;
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_full();
    if (rand_full) dma_fifo_full_i = ($urandom_range(0, 9) < 3);
  endtask

  // Presents a descriptor until accepted; queues the first n_exp writes it should produce.
  task automatic send_desc(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l,
                           input logic last, input int n_exp);
    logic [63:0] w[4];
    int n;
    n = 0;
    desc_valid_i = 1'b1;
    desc_src_i   = s;
    desc_dst_i   = d;
    desc_len_i   = l;
    desc_last_i  = last;
    #1;
    while (!desc_ready_o && n < 300) begin
      tick();
      randomize_full();
      #1;
      n++;
    end
    if (!desc_ready_o) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got desc_ready_o=0 for %0d cycles, required 1", n);
      desc_valid_i = 1'b0;
    end else begin
      w[0] = wr(32'h00, s);
      w[1] = wr(32'h04, d);
      w[2] = wr(32'h08, l);
      w[3] = wr(32'h0C, {30'b0, last, 1'b1});
      for (int i = 0; i < n_exp; i++) exp_q.push_back(w[i]);
      if (last && n_exp == 4 && model_out < MAX_OUT) model_out++;
      tick();
      desc_valid_i = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy_o || exp_q.size() != 0) && n < 500) begin
      tick();
      randomize_full();
      #1;
      n++;
    end
    if (busy_o || exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_timeout: got busy=%0b pending=%0d, required idle", busy_o, exp_q.size());
    end
    dma_fifo_full_i = 1'b0;
  endtask

  task automatic wait_pulse(input string name);
    int n;
    n = 0;
    #1;
    while (!chain_done_o && n < 20) begin
      tick();
      #1;
      n++;
    end
    check(name, chain_done_o, 1'b1);
  endtask

  initial begin
    tbl[0] = '{32'h0000_A000, 32'h0000_B000, 32'h0000_0080, 1'b0, 0};
    tbl[1] = '{32'h0000_A100, 32'h0000_B100, 32'h0000_0100, 1'b1, 1};
    tbl[2] = '{32'h0000_1000, 32'h0000_2000, 32'h0000_0040, 1'b1, 2};
    tbl[3] = '{32'hDEAD_BEE0, 32'h1234_5670, 32'hFFFF_FFFF, 1'b0, 2};

    rstn = 1'b0;
    desc_valid_i = 1'b1;
    desc_src_i = 32'h1; desc_dst_i = 32'h2; desc_len_i = 32'h3; desc_last_i = 1'b0;
    dma_fifo_full_i = 1'b0; dma_done_i = 1'b0; dma_error_i = 1'b0; soft_clear_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", desc_ready_o, 1'b0);
    check("reset_wr_en", csr_wr_en_o, 1'b0);
    check("reset_chain_done", chain_done_o, 1'b0);
    check("reset_outstanding", outstanding_o, 0);
    check("reset_busy", busy_o, 1'b0);
    check("reset_error", error_o, 1'b0);
    desc_valid_i = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Table vectors: write order through the scoreboard, chain count after each descriptor.
    for (int i = 0; i < 4; i++) begin
      send_desc(tbl[i].src, tbl[i].dst, tbl[i].len, tbl[i].last, 4);
      wait_idle();
      check("table_outstanding", outstanding_o, tbl[i].exp_out);
    end

    // FIFO full: IDLE refuses descriptors, WR_CTRL stalls 5 cycles then writes.
    dma_fifo_full_i = 1'b1;
    desc_valid_i = 1'b1; desc_last_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("full_idle_ready", desc_ready_o, 1'b0);
      tick();
    end
    dma_fifo_full_i = 1'b0;
    send_desc(32'h0000_3000, 32'h0000_4000, 32'h0000_0020, 1'b1, 4);
    dma_fifo_full_i = 1'b1;
    tick();
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      check("ctrl_stall_no_write", csr_wr_en_o, 1'b0);
      tick();
    end
    dma_fifo_full_i = 1'b0;
    #1;
    check("ctrl_after_stall", {csr_wr_en_o, csr_waddr_o, csr_wdata_o}, {1'b1, BASE + 32'hC, 32'h3});
    tick();
    check("stall_outstanding", outstanding_o, 3);

    // Error during WR_DST: DST write completes, then ERR until soft clear.
    send_desc(32'h0000_5000, 32'h0000_6000, 32'h0000_0010, 1'b1, 2);
    tick();
    dma_error_i = 1'b1;
    tick();
    dma_error_i = 1'b0;
    desc_valid_i = 1'b1;
    #1;
    check("err_flag", error_o, 1'b1);
    check("err_ready", desc_ready_o, 1'b0);
    check("err_busy", busy_o, 1'b1);
    for (int i = 0; i < 3; i++) tick();
    check("err_writes_blocked", exp_q.size(), 0);
    desc_valid_i = 1'b0;
    soft_clear_i = 1'b1;
    tick();
    soft_clear_i = 1'b0;
    model_out = 0;
    #1;
    check("clear_error", error_o, 1'b0);
    check("clear_outstanding", outstanding_o, 0);
    check("clear_busy", busy_o, 1'b0);

    // Two chains outstanding, then done held high: clear, holdoff, clear, then spurious.
    send_desc(32'h0000_7000, 32'h0000_8000, 32'h0000_0004, 1'b1, 4);
    send_desc(32'h0000_7100, 32'h0000_8100, 32'h0000_0008, 1'b1, 4);
    wait_idle();
    check("two_outstanding", outstanding_o, 2);
    exp_q.push_back(wr(32'h10, 32'h1));
    exp_q.push_back(wr(32'h10, 32'h1));
    dma_done_i = 1'b1;
    wait_pulse("clr_pulse_1");
    check("clr_addr", csr_waddr_o, BASE + 32'h10);
    check("clr_data", csr_wdata_o, 32'h1);
    tick();
    check("clr_out_dec", outstanding_o, 1);
    for (int i = 0; i < HOLD; i++) begin
      check("holdoff_quiet", {chain_done_o, csr_wr_en_o}, 2'b00);
      tick();
    end
    wait_pulse("clr_pulse_2");
    tick();
    check("clr_out_zero", outstanding_o, 0);
    for (int i = 0; i < 10; i++) begin
      check("spurious_quiet", {chain_done_o, csr_wr_en_o}, 2'b00);
      tick();
    end
    check("spurious_idle", busy_o, 1'b0);
    check("spurious_ready", desc_ready_o, 1'b1);
    dma_done_i = 1'b0;
    model_out = 0;

    // Randomized descriptors with random FIFO backpressure.
    rand_full = 1;
    for (int i = 0; i < 40; i++) begin
      logic lst;
      lst = ($urandom_range(0, 1) == 1) && (model_out < MAX_OUT);
      send_desc($urandom, $urandom, $urandom, lst, 4);
    end
    wait_idle();
    check("rand_outstanding", outstanding_o, model_out);
    while (model_out < MAX_OUT) send_desc($urandom, $urandom, $urandom, 1'b1, 4);
    wait_idle();
    rand_full = 0;
    dma_fifo_full_i = 1'b0;
    check("sat_value", outstanding_o, MAX_OUT);

    // Saturated: last descriptors are refused, continuations still pass.
    desc_valid_i = 1'b1; desc_last_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("sat_block_ready", desc_ready_o, 1'b0);
      tick();
    end
    desc_last_i = 1'b0;
    #1;
    check("sat_nonlast_ready", desc_ready_o, 1'b1);
    send_desc(32'h0000_9000, 32'h0000_9100, 32'h0000_0200, 1'b0, 4);
    wait_idle();
    check("sat_hold", outstanding_o, MAX_OUT);
    check("chain_done_count", n_done, 2);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
